// File: rtl/kp_i2s_tx.sv
// I2S transmitter for the Karplus-Strong voice: one-entry sample buffer, internal bclk/lrclk divider.
// Optional build macro KP_I2S_VOL_EN adds vol_shift, an arithmetic attenuation applied at frame start.
module kp_i2s_tx #(
  parameter int CLK_DIV = 4,
  parameter int SLOT_W  = 32
) (
  input  logic        a_clk,
  input  logic        reset_n,
  input  logic [23:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic        frame_start,
  output logic        underrun
`ifdef KP_I2S_VOL_EN
  ,
  input  logic [2:0]  vol_shift
`endif
);

  localparam int         CNT_W  = $clog2(2 * SLOT_W);
  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

  logic [7:0]       div_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_next;
  logic [CNT_W-2:0] slot_bit;
  logic [23:0]      hold;
  logic [23:0]      frame_word;
  logic [23:0]      load_word;
  logic             full;
  logic             fall;
  logic             frame_fire;
  logic             accept;
  logic             sdata_next;
`ifdef KP_I2S_VOL_EN
  logic [23:0]      raw_word;
  logic [23:0]      load_raw;
`endif

  assign sample_ready = ~full;

  always_comb begin
    fall       = (div_cnt == DIV_TC) && bclk;
    frame_fire = fall && (bit_cnt == '1);
    accept     = sample_valid && !full;
    bit_next   = bit_cnt + CNT_W'(1);
    slot_bit   = bit_next[CNT_W-2:0];
    sdata_next = 1'b0;
    // Slot bit 0 is the I2S one-bclk delay; bits 25..31 are zero padding.
    if (slot_bit >= 5'd1 && slot_bit <= 5'd24)
      sdata_next = frame_word[5'd24 - slot_bit];
`ifdef KP_I2S_VOL_EN
    // Underrun repeats the unattenuated word so the shift never compounds.
    load_raw  = full ? hold : raw_word;
    load_word = $signed(load_raw) >>> vol_shift;
`else
    load_word = full ? hold : frame_word;
`endif
  end

  always_ff @(posedge a_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      bclk        <= 1'b0;
      bit_cnt     <= '1;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      hold        <= '0;
      frame_word  <= '0;
      full        <= 1'b0;
`ifdef KP_I2S_VOL_EN
      raw_word    <= '0;
`endif
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;

      if (div_cnt == DIV_TC) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (fall) begin
        bit_cnt <= bit_next;
        lrclk   <= bit_next[CNT_W-1];
        sdata   <= sdata_next;
      end

      if (frame_fire) begin
        frame_word  <= load_word;
        frame_start <= 1'b1;
        underrun    <= ~full;
`ifdef KP_I2S_VOL_EN
        raw_word    <= load_raw;
`endif
      end

      // A same-cycle accept lands in hold; it is never forwarded into the starting frame.
      if (frame_fire && full) begin
        full <= 1'b0;
      end else if (accept) begin
        hold <= sample_in;
        full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kp_i2s_tx.sv
// Bench for kp_i2s_tx: cycle-level reference model, frame scoreboard decoded from sdata,
// a table of sample/expected-word vectors and hand-written reset/underrun sequences.
module tb_kp_i2s_tx;

  localparam int D = 4;

  logic        a_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic        frame_start;
  logic        underrun;
`ifdef KP_I2S_VOL_EN
  logic [2:0]  vol_shift = 3'd0;
`endif

  always #5 a_clk = ~a_clk;

  kp_i2s_tx #(.CLK_DIV(D)) dut (
    .a_clk        (a_clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun)
`ifdef KP_I2S_VOL_EN
    ,
    .vol_shift    (vol_shift)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Reference model: frame timing from cycle count, one-entry buffer, repeat-last on underrun.
  int          cyc = 0;
  bit          m_full = 0;
  logic [23:0] m_hold = '0;
  logic [23:0] m_last = '0;
  logic [23:0] exp_q[$];
  bit          exp_fs = 0;
  bit          exp_und = 0;
  bit          exp_ready = 1;

`ifdef KP_I2S_VOL_EN
  function automatic logic [23:0] shr(input logic [23:0] w, input logic [2:0] s);
    logic signed [23:0] t;
    t = w;
    return t >>> s;
  endfunction
`endif

  always @(posedge a_clk) begin
    bit acc;
    bit fs;
    if (!reset_n) begin
      cyc = 0; m_full = 0; m_hold = '0; m_last = '0;
      exp_q.delete();
      exp_fs = 0; exp_und = 0; exp_ready = 1;
    end else begin
      cyc++;
      acc = sample_valid && !m_full;
      fs = (cyc >= 2*D) && (((cyc - 2*D) % (128*D)) == 0);
      exp_fs = fs;
      exp_und = 0;
      if (fs) begin
        if (m_full) begin
          m_last = m_hold;
          m_full = 0;
        end else begin
          exp_und = 1;
        end
`ifdef KP_I2S_VOL_EN
        exp_q.push_back(shr(m_last, vol_shift));
`else
        exp_q.push_back(m_last);
`endif
      end
      if (acc) begin
        m_hold = sample_in;
        m_full = 1;
      end
      exp_ready = !m_full;
    end
  end

  // Monitor: per-cycle flag checks, and decoding of each frame at the DAC's bclk rises.
  bit          mon_active = 0;
  int          mon_pos = 0;
  logic        prev_bclk = 1'b0;
  logic [23:0] left_w = '0;
  logic [23:0] right_w = '0;
  logic        pad_or = 1'b0;
  logic        lr_err = 1'b0;
  int          frames_done = 0;
  logic [23:0] last_left = '0;
  int          und_seen = 0;

  always @(negedge a_clk) begin
    int b;
    logic [23:0] e;
    if (!reset_n) begin
      mon_active = 0;
      prev_bclk = 1'b0;
    end else begin
      chk("bclk_phase", 32'(bclk), 32'((cyc / D) % 2));
      chk("frame_start", 32'(frame_start), 32'(exp_fs));
      chk("underrun", 32'(underrun), 32'(exp_und));
      chk("sample_ready", 32'(sample_ready), 32'(exp_ready));
      if (underrun) und_seen++;
      if (bclk && !prev_bclk && mon_active) begin
        b = mon_pos % 32;
        if (lrclk !== (mon_pos >= 32)) lr_err = 1'b1;
        if (b >= 1 && b <= 24) begin
          if (mon_pos < 32) left_w[24-b] = sdata;
          else right_w[24-b] = sdata;
        end else begin
          pad_or = pad_or | sdata;
        end
        if (mon_pos == 63) begin
          if (exp_q.size() == 0) begin
            fail_now("scoreboard_empty");
          end else begin
            e = exp_q.pop_front();
            chk("left_word", 32'(left_w), 32'(e));
            chk("right_word", 32'(right_w), 32'(e));
            chk("pad_bits", 32'(pad_or), 32'd0);
            chk("lrclk_slot", 32'(lr_err), 32'd0);
          end
          last_left = left_w;
          frames_done++;
          mon_active = 0;
        end
        mon_pos++;
      end
      prev_bclk = bclk;
      if (exp_fs) begin
        mon_active = 1; mon_pos = 0;
        left_w = '0; right_w = '0; pad_or = 1'b0; lr_err = 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    chk("rst_bclk", 32'(bclk), 32'd0);
    chk("rst_lrclk", 32'(lrclk), 32'd0);
    chk("rst_sdata", 32'(sdata), 32'd0);
    chk("rst_ready", 32'(sample_ready), 32'd1);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    repeat (3) @(posedge a_clk);
    @(negedge a_clk);
    reset_n = 1'b1;
  endtask

  task automatic first_fs_check();
    int n = 0;
    do begin
      @(posedge a_clk); #1; n++;
    end while (!frame_start && n < 100);
    chk("first_fs_cycle", 32'(n), 32'(2*D));
    chk("first_fs_underrun", 32'(underrun), 32'd1);
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    do begin
      @(negedge a_clk); #1; n++;
    end while (!sample_ready && n < 1200);
    if (!sample_ready) fail_now(name);
  endtask

  task automatic wait_done(input string name);
    int base = frames_done;
    int n = 0;
    while (frames_done == base && n < 1200) begin
      @(negedge a_clk); #1; n++;
    end
    if (frames_done == base) fail_now(name);
  endtask

  task automatic wait_lrclk(input logic v, input string name);
    int n = 0;
    while (lrclk !== v && n < 1200) begin
      @(negedge a_clk); #1; n++;
    end
    if (lrclk !== v) fail_now(name);
  endtask

  task automatic push(input logic [23:0] s);
    wait_ready("push_ready");
    sample_in = s;
    sample_valid = 1'b1;
    @(posedge a_clk); #1;
    sample_valid = 1'b0;
  endtask

  typedef struct {
    logic [23:0] smp;
    logic [2:0]  vol;
    logic [23:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int und0;
    bit acc;

    tbl.push_back('{24'h800001, 3'd0, 24'h800001, "word_800001"});
    tbl.push_back('{24'h123456, 3'd0, 24'h123456, "word_123456"});
    tbl.push_back('{24'hFEDCBA, 3'd0, 24'hFEDCBA, "word_FEDCBA"});
`ifdef KP_I2S_VOL_EN
    tbl.push_back('{24'h800000, 3'd3, 24'hF00000, "vol3_800000"});
    tbl.push_back('{24'h7FFFF8, 3'd2, 24'h1FFFFE, "vol2_7FFFF8"});
`endif

    // Idle after reset: first frame underruns and carries zeros.
    do_reset();
    first_fs_check();
    wait_done("idle_frame1");
    wait_done("idle_frame2");
    chk("idle_word", 32'(last_left), 32'd0);

    // Table: each sample offered as soon as the buffer is free; first one before the first frame.
    do_reset();
    foreach (tbl[i]) begin
`ifdef KP_I2S_VOL_EN
      vol_shift = tbl[i].vol;
`endif
      push(tbl[i].smp);
      wait_ready("load_ready");
      wait_done("load_frame");
      chk(tbl[i].name, 32'(last_left), 32'(tbl[i].exp));
    end
`ifdef KP_I2S_VOL_EN
    vol_shift = 3'd0;
`endif

    // Producer holds valid high with an incrementing value.
    sample_in = 24'h000100;
    sample_valid = 1'b1;
    repeat (5*128*D) begin
      @(negedge a_clk); #1;
      acc = sample_ready;
      @(posedge a_clk); #1;
      if (acc) sample_in = sample_in + 24'd1;
    end
    sample_valid = 1'b0;
    wait_ready("stream_ready");
    wait_done("stream_frame");
    chk("stream_last", 32'(last_left), 32'(24'(sample_in - 24'd1)));

    // Producer stalls for one frame after 00000F.
    push(24'h00000F);
    wait_ready("stall_ready");
    wait_done("stall_frame1");
    chk("stall_word1", 32'(last_left), 32'h00000F);
    und0 = und_seen;
    wait_done("stall_frame2");
    chk("stall_word2", 32'(last_left), 32'h00000F);
    chk("stall_underruns", 32'(und_seen - und0), 32'd1);

    // Reset in the middle of the right slot with a sample pending.
    wait_lrclk(1'b0, "lrclk_left");
    wait_lrclk(1'b1, "lrclk_right");
    push(24'hABCDEF);
    chk("pending_ready", 32'(sample_ready), 32'd0);
    repeat (5) @(negedge a_clk);
    #2;
    do_reset();
    first_fs_check();
    wait_done("post_reset_frame");
    chk("post_reset_word", 32'(last_left), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
